// File: rtl/riscv_pkg.sv
// Shared encodings for the pipelined RISC-V core: write-back source selects and load funct3 codes.
package riscv_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load extraction: picks the addressed byte/halfword out of an aligned word
// and sign- or zero-extends it.
module load_extend
  import riscv_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   addrLo,
  input  logic [N-1:0] readData,
  output logic [N-1:0] extData
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    unique case (addrLo)
      2'd0:    byteVal = readData[7:0];
      2'd1:    byteVal = readData[15:8];
      2'd2:    byteVal = readData[23:16];
      default: byteVal = readData[31:24];
    endcase
    // Halfword accesses only look at addrLo[1]; a misaligned bit 0 is ignored.
    halfVal = addrLo[1] ? readData[31:16] : readData[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   extData = {{(N-8){byteVal[7]}}, byteVal};
      F3_LBU:  extData = {{(N-8){1'b0}}, byteVal};
      F3_LH:   extData = {{(N-16){halfVal[15]}}, halfVal};
      F3_LHU:  extData = {{(N-16){1'b0}}, halfVal};
      default: extData = readData;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: load extraction, write-back select,
// register-file write port and the retired-instruction counter.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         mem_valid,
  input  logic         mem_reg_write,
  input  logic [4:0]   mem_rd,
  input  logic [1:0]   mem_wb_sel,
  input  logic [2:0]   mem_funct3,
  input  logic [1:0]   mem_addr_lo,
  input  logic [N-1:0] mem_alu_result,
  input  logic [N-1:0] mem_read_data,
  input  logic [N-1:0] mem_pc_plus4,
  input  logic [N-1:0] mem_imm,
  output logic         RegWrite,
  output logic [4:0]   WriteReg,
  output logic [N-1:0] WriteData,
  output logic         wb_valid,
  output logic [63:0]  instret
);

  logic         validQ;
  logic         regWriteQ;
  logic [4:0]   rdQ;
  logic [N-1:0] dataQ;
  logic [N-1:0] dataD;
  logic [N-1:0] loadData;
  logic [63:0]  instretQ;
  logic [63:0]  instretD;
  logic         capture;

  load_extend #(
    .N(N)
  ) u_load_extend (
    .funct3  (mem_funct3),
    .addrLo  (mem_addr_lo),
    .readData(mem_read_data),
    .extData (loadData)
  );

  assign capture = !flush && !stall;

  always_comb begin
    case (mem_wb_sel)
      WB_SEL_LOAD: dataD = loadData;
      WB_SEL_PC4:  dataD = mem_pc_plus4;
      WB_SEL_IMM:  dataD = mem_imm;
      default:     dataD = mem_alu_result;
    endcase
  end

  always_comb begin
    instretD = instretQ;
    if (capture && mem_valid) instretD = instretQ + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ    <= 1'b0;
      regWriteQ <= 1'b0;
      rdQ       <= '0;
      dataQ     <= '0;
      instretQ  <= '0;
    end else begin
      if (flush) begin
        validQ    <= 1'b0;
        regWriteQ <= 1'b0;
      end else if (!stall) begin
        validQ    <= mem_valid;
        regWriteQ <= mem_valid & mem_reg_write;
        rdQ       <= mem_rd;
        dataQ     <= dataD;
      end
      instretQ <= instretD;
    end
  end

  // x0 is hardwired to zero, so never present a write to it.
  assign RegWrite  = validQ & regWriteQ & (rdQ != 5'd0);
  assign WriteReg  = rdQ;
  assign WriteData = dataQ;
  assign wb_valid  = validQ;
  assign instret   = instretQ;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed literal checks plus randomized traffic against a
// behavioural model, with a per-cycle compare process.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel, mem_addr_lo;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_read_data, mem_pc_plus4, mem_imm;
  logic        RegWrite, wb_valid;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [63:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_instret;
  logic        force_pre = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage #(.N(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_wb_sel    (mem_wb_sel),
    .mem_funct3    (mem_funct3),
    .mem_addr_lo   (mem_addr_lo),
    .mem_alu_result(mem_alu_result),
    .mem_read_data (mem_read_data),
    .mem_pc_plus4  (mem_pc_plus4),
    .mem_imm       (mem_imm),
    .RegWrite      (RegWrite),
    .WriteReg      (WriteReg),
    .WriteData     (WriteData),
    .wb_valid      (wb_valid),
    .instret       (instret)
  );

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wb_value();
    case (mem_wb_sel)
      2'd0:    return mem_alu_result;
      2'd1:    return load_value(mem_funct3, mem_addr_lo, mem_read_data);
      2'd2:    return mem_pc_plus4;
      default: return mem_imm;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_rd <= '0; m_data <= '0; m_instret <= '0;
    end else begin
      if (force_pre) m_instret <= 64'hFFFF_FFFF_FFFF_FFFE;
      else if (!flush && !stall && mem_valid) m_instret <= m_instret + 64'd1;
      if (flush) begin
        m_valid <= 1'b0; m_rw <= 1'b0;
      end else if (!stall) begin
        m_valid <= mem_valid;
        m_rw    <= mem_valid && mem_reg_write;
        m_rd    <= mem_rd;
        m_data  <= wb_value();
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are stable between edges, so sample on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_wb_valid", {63'd0, wb_valid}, {63'd0, m_valid});
      check("cmp_RegWrite", {63'd0, RegWrite}, {63'd0, m_valid && m_rw && (m_rd != 0)});
      check("cmp_instret", instret, m_instret);
      if (m_valid) begin
        check("cmp_WriteReg", {59'd0, WriteReg}, {59'd0, m_rd});
        check("cmp_WriteData", {32'd0, WriteData}, {32'd0, m_data});
      end
    end
  end

  task automatic issue(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                       input logic [31:0] alu, input logic [31:0] rdata);
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_addr_lo = lo; mem_alu_result = alu; mem_read_data = rdata;
    mem_pc_plus4 = 32'h104; mem_imm = 32'h1234_5000;
  endtask

  initial begin
    rst = 1'b1; stall = 0; flush = 0;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    check("reset_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("reset_WriteData", {32'd0, WriteData}, 64'd0);
    check("reset_instret", instret, 64'd0);
    rst = 1'b0;

    // Loads from 0x80F1_7F82
    issue(1, 1, 5'd9, 2'b01, 3'b000, 2'd0, 0, 32'h80F1_7F82); @(negedge clk);
    check("lb_0", {32'd0, WriteData}, 64'hFFFF_FF82);
    issue(1, 1, 5'd9, 2'b01, 3'b100, 2'd1, 0, 32'h80F1_7F82); @(negedge clk);
    check("lbu_1", {32'd0, WriteData}, 64'h0000_007F);
    issue(1, 1, 5'd9, 2'b01, 3'b001, 2'd2, 0, 32'h80F1_7F82); @(negedge clk);
    check("lh_2", {32'd0, WriteData}, 64'hFFFF_80F1);
    issue(1, 1, 5'd9, 2'b01, 3'b101, 2'd3, 0, 32'h80F1_7F82); @(negedge clk);
    check("lhu_3", {32'd0, WriteData}, 64'h0000_80F1);
    issue(1, 1, 5'd9, 2'b01, 3'b010, 2'd1, 0, 32'h80F1_7F82); @(negedge clk);
    check("lw", {32'd0, WriteData}, 64'h80F1_7F82);

    // Write-back mux
    issue(1, 1, 5'd5, 2'b00, 0, 0, 32'h10, 0); @(negedge clk);
    check("sel_alu", {32'd0, WriteData}, 64'h10);
    check("sel_alu_we", {58'd0, RegWrite, WriteReg}, {58'd0, 1'b1, 5'd5});
    issue(1, 1, 5'd5, 2'b10, 0, 0, 32'h10, 0); @(negedge clk);
    check("sel_pc4", {32'd0, WriteData}, 64'h104);
    check("sel_pc4_we", {58'd0, RegWrite, WriteReg}, {58'd0, 1'b1, 5'd5});
    issue(1, 1, 5'd5, 2'b11, 0, 0, 32'h10, 0); @(negedge clk);
    check("sel_imm", {32'd0, WriteData}, 64'h1234_5000);
    check("sel_imm_we", {58'd0, RegWrite, WriteReg}, {58'd0, 1'b1, 5'd5});
    issue(1, 1, 5'd0, 2'b00, 0, 0, 32'h10, 0); @(negedge clk);
    check("rd0_no_write", {63'd0, RegWrite}, 64'd0);
    check("rd0_instret", instret, 64'd9);

    // Stall holds the captured rd=7
    issue(1, 1, 5'd7, 2'b00, 0, 0, 32'h77, 0); @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1, 1, 5'(20 + i), 2'b10, 0, 0, 32'hAA + i, 0); @(negedge clk);
      check("stall_hold", {26'd0, RegWrite, WriteReg, WriteData}, {26'd0, 1'b1, 5'd7, 32'h77});
    end
    check("stall_instret", instret, 64'd10);
    flush = 1'b1; @(negedge clk);
    check("flush_over_stall", {62'd0, wb_valid, RegWrite}, 64'd0);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset with a valid instruction in WB
    issue(1, 1, 5'd3, 2'b00, 0, 0, 32'h33, 0); @(negedge clk);
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", {25'd0, RegWrite, wb_valid, WriteReg, WriteData}, 64'd0);
    check("async_rst_instret", instret, 64'd0);
    @(negedge clk); rst = 1'b0;

    // instret wrap: preload via the counter's next-state, then retire three
    force_pre = 1'b1;
    force dut.instretD = 64'hFFFF_FFFF_FFFF_FFFE;
    @(posedge clk); #1;
    release dut.instretD;
    force_pre = 1'b0;
    @(negedge clk);
    check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(1, 1, 5'd1, 2'b00, 0, 0, 32'h1, 0); @(negedge clk);
    check("wrap_ff", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("wrap_0", instret, 64'd0);
    @(negedge clk);
    check("wrap_1", instret, 64'd1);

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) < 1);
      issue($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 2'($urandom),
            3'($urandom), 2'($urandom), $urandom, $urandom);
      mem_pc_plus4 = $urandom;
      mem_imm = $urandom;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and write-back stage of the pipelined RISC-V core. It captures the memory-stage results at each clock edge and performs load byte/halfword extraction with sign/zero extension. It selects the write-back value and drives the register file write port (RegWrite, WriteReg, WriteData). It also keeps a 64-bit retired-instruction counter.

## Interface
- Clock `clk`; reset `rst`, asynchronous, active-high.

Parameters:
- N, 32, datapath width. Only N=32 is supported for load extraction.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- stall  in  1  hold the MEM/WB register contents
- flush  in  1  load a bubble (valid=0)
- mem_valid  in  1  the MEM stage holds a real instruction
- mem_reg_write  in  1  the instruction writes rd
- mem_rd  in  5  destination register
- mem_wb_sel  in  2  write-back source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- mem_funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- mem_addr_lo  in  2  low bits of the load address
- mem_alu_result  in  N  ALU result
- mem_read_data  in  N  raw aligned data-memory word
- mem_pc_plus4  in  N  PC+4 of the instruction
- mem_imm  in  N  U-type immediate
- RegWrite  out  1  register file write enable
- WriteReg  out  5  register file write address
- WriteData  out  N  register file write data
- wb_valid  out  1  the WB stage holds a valid instruction
- instret  out  64  count of retired instructions

## Operation
- State: valid, reg_write, rd, data[N-1:0], instret[63:0].
- Priority at each clock edge: rst > flush > stall > capture.
  - flush: valid←0, reg_write←0. rd and data are don't-care.
  - stall (flush=0): all fields hold.
  - capture: valid←mem_valid; reg_write←mem_valid & mem_reg_write; rd←mem_rd; data←selected value.
- The write-back value is selected combinationally before the register, so WriteData is always a registered value.
- Load extraction (only when mem_wb_sel=01):
  - lb/lbu: byte = mem_read_data[8*addr_lo +: 8]. lb sign-extends, lbu zero-extends.
  - lh/lhu: half = mem_read_data[16*addr_lo[1] +: 16]; addr_lo[0] is ignored. lh sign-extends, lhu zero-extends.
  - lw and the unused codes 011, 110, 111: the full word; addr_lo is ignored.
- Outputs:
  - RegWrite = valid & reg_write & (rd != 0), so x0 is never written.
  - WriteReg = rd; WriteData = data; wb_valid = valid.
- instret increments by 1 on an edge where a capture occurs with mem_valid=1. It wraps 0xFFFF_FFFF_FFFF_FFFF → 0.
- During a stall, RegWrite stays asserted with the same rd and data. The register file rewrites the same value each cycle; this is intentional and harmless. instret does not increment while stalled.

## Timing
- Latency 1 cycle: MEM inputs sampled at edge k appear on the outputs after edge k.
- Reset (asynchronous, effective immediately): valid=0, reg_write=0, rd=0, data=0, instret=0. So RegWrite=0, WriteReg=0, WriteData=0, wb_valid=0.
- Reset in mid-stall discards the held instruction; instret returns to 0.
- flush and stall asserted together: the flush wins and a bubble is loaded.
- mem_valid=0 with mem_reg_write=1: no write occurs and instret does not count.
- The register file writes at the next rising edge after RegWrite is seen. That makes this stage's output the register-file write of the following cycle; the forwarding logic reads WriteReg/WriteData directly.

## Structure
- Shared package `riscv_pkg`:
  - WB_SEL_ALU/LOAD/PC4/IMM encodings.
  - funct3 load constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- Sub-module `load_extend`: purely combinational. Inputs funct3, addr_lo, read_data; output the extended word.
- The top level holds the pipeline register, the write-back mux and the instret counter.

## Test plan
- Reset: assert rst mid-cycle with valid=1 in WB → outputs go to 0 immediately, without waiting for a clock edge; instret=0.
- Loads with mem_read_data=0x80F1_7F82, one per cycle:
  - lb addr_lo=0 → WriteData 0xFFFF_FF82
  - lbu addr_lo=1 → 0x0000_007F
  - lh addr_lo=2 → 0xFFFF_80F1
  - lhu addr_lo=3 → 0x0000_80F1
  - lw → 0x80F1_7F82
- Write-back mux with alu=0x10, pc4=0x104, imm=0x12345000, rd=5:
  - sel 00/10/11 → WriteData 0x10 / 0x104 / 0x12345000, each with RegWrite=1 and WriteReg=5.
  - rd=0 with mem_reg_write=1 → RegWrite=0, and instret still increments.
- Stall/flush:
  - Capture rd=7, then stall 3 cycles with the inputs changing → outputs hold rd=7 and its data; instret +1 total.
  - Assert flush and stall together → wb_valid=0, RegWrite=0.
- instret wrap: issue 3 valid instructions with instret preloaded (via force) to 0xFFFF_FFFF_FFFF_FFFE → instret sequence FF…FF, 0, 1.
